// File: rtl/chip8_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chip8_fetch : CHIP-8 instruction fetch (PC, two-byte read, valid/ready)   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module chip8_fetch #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] PC_RESET = 12'h200
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_HI  = 3'd1;
  localparam logic [2:0] S_RD_LO  = 3'd2;
  localparam logic [2:0] S_CAP_LO = 3'd3;
  localparam logic [2:0] S_VALID  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       instr_out_q, instr_out_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_RESET;
      hi_q          <= 8'h00;
      instr_out_q   <= 16'h0000;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hi_q          <= hi_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // A redirect overrides every state and throws away any partially fetched opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fetch_en) state_d = S_RD_HI;
      S_RD_HI:  state_d = S_RD_LO;
      S_RD_LO:  state_d = S_CAP_LO;
      S_CAP_LO: state_d = S_VALID;
      S_VALID:  if (instr_ready) state_d = fetch_en ? S_RD_HI : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (pc_load) state_d = S_IDLE;
  end

  always_comb begin
    pc_d          = pc_q;
    hi_d          = hi_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    if (pc_load) begin
      pc_d          = pc_load_val;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_RD_LO:  hi_d = mem_rdata;
        S_CAP_LO: begin
          instr_out_d   = {hi_q, mem_rdata};
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
        end
        S_VALID: if (instr_ready) begin
          pc_d          = pc_q + ADDR_W'(2);
          instr_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd_en   = (state_q == S_RD_HI) || (state_q == S_RD_LO);
    mem_addr    = (state_q == S_RD_LO) ? pc_q + ADDR_W'(1) : pc_q;
    busy        = (state_q != S_IDLE);
    instr_out   = instr_out_q;
    instr_pc    = instr_pc_q;
    instr_valid = instr_valid_q;
    pc_out      = pc_q;
  end

endmodule
`default_nettype wire
